pio_dip_sw_edge_ctrl: RTL

Avalon-MM slave controller that sits in front of the raw DIP-switch PIO input. It synchronises and debounces the switch lines and detects selectable edges into a write-1-to-clear capture register. It raises a maskable level interrupt to the Nios II.

---
 rtl/pio_dip_sw_edge_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/pio_dip_sw_edge_ctrl.sv
// DIP-switch PIO front end: synchronise, debounce and capture selectable edges of the
// switch lines into a W1C register, with a maskable level interrupt.
module pio_dip_sw_edge_ctrl #(
  parameter int unsigned WIDTH            = 4,
  parameter logic [15:0] PRESCALE_DEFAULT = 16'd49999,
  parameter int unsigned DB_COUNT         = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [3:0] DB_LAST = 4'(DB_COUNT - 1);

  logic [WIDTH-1:0] sync1, sync2, deb, deb_d;
  logic [WIDTH-1:0] edge_cap, mask;
  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic [3:0]       db_cnt [WIDTH];
  logic [15:0]      reload, pre_cnt;
  logic [1:0]       edge_sel;
  logic             wr_en, ctrl_wr, mask_wr, edge_wr, tick;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign unused_wd = ^writedata[31:18];

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en && (address == 2'd3);
  assign mask_wr = wr_en && (address == 2'd1);
  assign edge_wr = wr_en && (address == 2'd2);
  assign clr     = edge_wr ? writedata[WIDTH-1:0] : '0;

  // A CTRL write reloads the counter directly, so a zero count in that cycle must not tick.
  assign tick = (pre_cnt == 16'd0) && !ctrl_wr;

  assign rise = deb & ~deb_d;
  assign fall = ~deb & deb_d;

  always_comb begin
    ev = rise;
    if (edge_sel[1])
      ev = rise | fall;
    else if (edge_sel[0])
      ev = fall;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[WIDTH-1:0] = deb;
      2'd1: rd_mux[WIDTH-1:0] = mask;
      2'd2: rd_mux[WIDTH-1:0] = edge_cap;
      default: rd_mux[17:0] = {edge_sel, reload};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb_d    <= '0;
      edge_cap <= '0;
      mask     <= '0;
      reload   <= PRESCALE_DEFAULT;
      edge_sel <= 2'b00;
      pre_cnt  <= PRESCALE_DEFAULT;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      deb_d    <= deb;
      edge_cap <= (edge_cap & ~clr) | ev;
      readdata <= rd_mux;
      irq      <= |(edge_cap & mask);
      if (mask_wr)
        mask <= writedata[WIDTH-1:0];
      if (ctrl_wr) begin
        reload   <= writedata[15:0];
        edge_sel <= writedata[17:16];
        pre_cnt  <= writedata[15:0];
      end else if (pre_cnt == 16'd0) begin
        pre_cnt  <= reload;
      end else begin
        pre_cnt  <= pre_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      deb <= '0;
      for (int unsigned i = 0; i < WIDTH; i++)
        db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (tick) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

endmodule
